// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two requester ports (cpu_*, ldr_*) and the shared single-port
// memory port of mem_arbiter.
//
// Handshake: a requester raises *_req with *_we/*_addr/*_wdata valid and keeps
// them stable until it sees *_ack. *_ack is a one-cycle completion pulse; on a
// read, *_rdata is valid from the ack cycle and holds until that port's next
// completed read. The request is captured once, when granted, so dropping
// *_req after the grant does not cancel the transaction.
//
// Parameters: AW address width, DW data width.
// Modports:
//   slave  - arbiter side (requests/mem_rdata in; acks, rdata, memory strobes out)
//   master - environment side (mirror of slave)
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic [DW-1:0] ldr_rdata;
    logic          ldr_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a processor port (cpu_*) and a loader port (ldr_*) onto one
// single-port memory with a fixed access latency of WAIT_CYCLES cycles.
// A transaction is IDLE (grant) -> ACCESS (WAIT_CYCLES cycles, mem_en high)
// -> RESP (one-cycle ack) -> IDLE, so back-to-back transactions issue every
// WAIT_CYCLES+2 cycles.
//
// Parameters:
//   WAIT_CYCLES  memory latency in cycles, legal 1..15 (4-bit counter)
//   AW, DW       address / data width
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high; aborts any transaction with no ack
//   bus          mem_arbiter_if.slave (requester ports + memory port)
//   busy         high whenever the FSM is not IDLE
//   state_dbg    current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Configuration macro ARB_ROUND_ROBIN_EN:
//   defined   - on simultaneous requests the port not granted most recently
//               wins; a last-winner register tracks every grant
//   undefined - fixed priority, loader always beats cpu
// A lone request is granted the same way in both builds.
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_if.slave     bus,
    output logic             busy,
    output logic [1:0]       state_dbg
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          win_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ldr_rdata_q;

    logic any_req;
    logic grant;

    assign any_req = bus.cpu_req | bus.ldr_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Port granted most recently; reset to loader so the cpu wins the first
    // contested arbitration after reset.
    logic last_q;

    always_comb begin
        grant = PORT_CPU;
        if (bus.cpu_req && bus.ldr_req) begin
            grant = (last_q == PORT_CPU) ? PORT_LDR : PORT_CPU;
        end else if (bus.ldr_req) begin
            grant = PORT_LDR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PORT_LDR;
        end else if (state == ST_IDLE && any_req) begin
            last_q <= grant;
        end
    end
`else
    assign grant = bus.ldr_req ? PORT_LDR : PORT_CPU;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            win_q       <= PORT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        // The winner's command is captured here so the
                        // requester may drop req right after the grant.
                        win_q <= grant;
                        if (grant == PORT_LDR) begin
                            we_q    <= bus.ldr_we;
                            addr_q  <= bus.ldr_addr;
                            wdata_q <= bus.ldr_wdata;
                        end else begin
                            we_q    <= bus.cpu_we;
                            addr_q  <= bus.cpu_addr;
                            wdata_q <= bus.cpu_wdata;
                        end
                        cnt   <= CNT_LOAD;
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= ST_RESP;
                        // Read data is valid on the last access cycle; writes
                        // leave both rdata registers untouched.
                        if (!we_q) begin
                            if (win_q == PORT_LDR) begin
                                ldr_rdata_q <= bus.mem_rdata;
                            end else begin
                                cpu_rdata_q <= bus.mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address/data hold their last latched values; only the strobes are gated.
    assign bus.mem_en    = (state == ST_ACCESS);
    assign bus.mem_we    = (state == ST_ACCESS) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.cpu_ack   = (state == ST_RESP) & (win_q == PORT_CPU);
    assign bus.ldr_ack   = (state == ST_RESP) & (win_q == PORT_LDR);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ldr_rdata = ldr_rdata_q;

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) b2 ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) b15 ();

    logic       busy2, busy1, busy15;
    logic [1:0] st2, st1, st15;

    mem_arbiter #(.WAIT_CYCLES(2), .AW(AW), .DW(DW)) dut2 (
        .clk(clk), .reset(rst), .bus(b2), .busy(busy2), .state_dbg(st2));
    mem_arbiter #(.WAIT_CYCLES(1), .AW(AW), .DW(DW)) dut1 (
        .clk(clk), .reset(rst), .bus(b1), .busy(busy1), .state_dbg(st1));
    mem_arbiter #(.WAIT_CYCLES(15), .AW(AW), .DW(DW)) dut15 (
        .clk(clk), .reset(rst), .bus(b15), .busy(busy15), .state_dbg(st15));

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        b2.cpu_req = 0; b2.cpu_we = 0; b2.cpu_addr = '0; b2.cpu_wdata = '0;
        b2.ldr_req = 0; b2.ldr_we = 0; b2.ldr_addr = '0; b2.ldr_wdata = '0;
        b2.mem_rdata = '0;
        b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
        b1.ldr_req = 0; b1.ldr_we = 0; b1.ldr_addr = '0; b1.ldr_wdata = '0;
        b1.mem_rdata = '0;
        b15.cpu_req = 0; b15.cpu_we = 0; b15.cpu_addr = '0; b15.cpu_wdata = '0;
        b15.ldr_req = 0; b15.ldr_we = 0; b15.ldr_addr = '0; b15.ldr_wdata = '0;
        b15.mem_rdata = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        b2.mem_rdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (st2 !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", st2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy2); end
        checks++; if (b2.cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack got=%b exp=0", b2.cpu_ack); end
        checks++; if (b2.ldr_ack !== 1'b0) begin errors++; $display("FAIL reset_ldr_ack got=%b exp=0", b2.ldr_ack); end
        checks++; if (b2.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%b exp=0", b2.mem_en); end
        checks++; if (b2.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", b2.mem_we); end
        checks++; if (b2.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", b2.mem_addr); end
        checks++; if (b2.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", b2.mem_wdata); end
        checks++; if (b2.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata got=%h exp=0", b2.cpu_rdata); end
        checks++; if (b2.ldr_rdata !== 32'h0) begin errors++; $display("FAIL reset_ldr_rdata got=%h exp=0", b2.ldr_rdata); end
        checks++; if (busy1 !== 1'b0 || busy15 !== 1'b0) begin errors++; $display("FAIL reset_busy_sweep got=%b%b exp=00", busy1, busy15); end
    endtask

    task automatic test_cpu_read();
        int en_cnt = 0, we_cnt = 0, bad_addr = 0, ack_cnt = 0, ldr_ack_cnt = 0, ack_at = -1;
        @(posedge clk); #1;
        b2.mem_rdata = 32'hDEAD_BEEF;
        b2.cpu_we = 1'b0; b2.cpu_addr = 32'h0000_0010; b2.cpu_wdata = 32'hFFFF_FFFF;
        b2.cpu_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (b2.mem_en) begin
                en_cnt++;
                if (b2.mem_we) we_cnt++;
                if (b2.mem_addr !== 32'h0000_0010) bad_addr++;
            end
            if (b2.ldr_ack) ldr_ack_cnt++;
            if (b2.cpu_ack) begin ack_cnt++; ack_at = k; b2.cpu_req = 1'b0; end
        end
        checks++; if (en_cnt != 2) begin errors++; $display("FAIL rd_mem_en_cycles got=%0d exp=2", en_cnt); end
        checks++; if (we_cnt != 0) begin errors++; $display("FAIL rd_mem_we_cycles got=%0d exp=0", we_cnt); end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL rd_mem_addr bad_cycles=%0d exp=0", bad_addr); end
        checks++; if (ack_cnt != 1) begin errors++; $display("FAIL rd_ack_count got=%0d exp=1", ack_cnt); end
        checks++; if (ack_at != 3) begin errors++; $display("FAIL rd_ack_latency got=N+%0d exp=N+3", ack_at); end
        checks++; if (ldr_ack_cnt != 0) begin errors++; $display("FAIL rd_ldr_ack got=%0d exp=0", ldr_ack_cnt); end
        checks++; if (b2.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_cpu_rdata got=%h exp=deadbeef", b2.cpu_rdata); end
        checks++; if (b2.ldr_rdata !== 32'h0) begin errors++; $display("FAIL rd_ldr_rdata got=%h exp=0", b2.ldr_rdata); end
    endtask

    task automatic test_ldr_write();
        int we_cnt = 0, bad_ad = 0, ack_cnt = 0, ack_at = -1;
        @(posedge clk); #1;
        b2.mem_rdata = 32'hCAFE_F00D;
        b2.ldr_we = 1'b1; b2.ldr_addr = 32'h0000_0020; b2.ldr_wdata = 32'h1234_5678;
        b2.ldr_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (b2.mem_we) begin
                we_cnt++;
                if (b2.mem_addr !== 32'h0000_0020 || b2.mem_wdata !== 32'h1234_5678 || !b2.mem_en) bad_ad++;
            end
            if (b2.ldr_ack) begin ack_cnt++; ack_at = k; b2.ldr_req = 1'b0; end
        end
        checks++; if (we_cnt != 2) begin errors++; $display("FAIL wr_mem_we_cycles got=%0d exp=2", we_cnt); end
        checks++; if (bad_ad != 0) begin errors++; $display("FAIL wr_addr_data bad_cycles=%0d exp=0", bad_ad); end
        checks++; if (ack_cnt != 1 || ack_at != 3) begin errors++; $display("FAIL wr_ack got=%0d@N+%0d exp=1@N+3", ack_cnt, ack_at); end
        checks++; if (b2.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_cpu_rdata got=%h exp=deadbeef", b2.cpu_rdata); end
        checks++; if (b2.ldr_rdata !== 32'h0) begin errors++; $display("FAIL wr_ldr_rdata got=%h exp=0", b2.ldr_rdata); end
        checks++; if (b2.mem_addr !== 32'h0000_0020 || b2.mem_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL wr_hold_addr_data got=%h/%h exp=00000020/12345678", b2.mem_addr, b2.mem_wdata);
        end
        checks++; if (b2.mem_en !== 1'b0 || b2.mem_we !== 1'b0) begin errors++; $display("FAIL wr_idle_strobes got=%b%b exp=00", b2.mem_en, b2.mem_we); end
        b2.ldr_we = 1'b0;
    endtask

    task automatic test_contention();
        exp_q.delete();
        got_q.delete();
        // bit7 = port (1 ldr, 0 cpu), low bits = ack cycle offset from N
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back(8'h03); exp_q.push_back(8'h87); exp_q.push_back(8'h0B);
`else
        exp_q.push_back(8'h83); exp_q.push_back(8'h87); exp_q.push_back(8'h8B);
`endif
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        b2.cpu_addr = 32'h0000_0100; b2.ldr_addr = 32'h0000_0200;
        b2.mem_rdata = 32'hA5A5_0001;
        b2.cpu_req = 1'b1; b2.ldr_req = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (b2.cpu_ack) got_q.push_back({1'b0, 7'(k)});
            if (b2.ldr_ack) got_q.push_back({1'b1, 7'(k)});
        end
        b2.cpu_req = 1'b0; b2.ldr_req = 1'b0;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL arb_ack_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL arb_ack_%0d got=port%0d@N+%0d exp=port%0d@N+%0d", i, got_q[i][7], got_q[i][6:0], exp_q[i][7], exp_q[i][6:0]);
            end
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_pulse_req();
        int ack_cnt = 0, ack_at = -1;
        logic busy_seen = 1'b0;
        @(posedge clk); #1;
        b2.mem_rdata = 32'h0BAD_F00D;
        b2.cpu_we = 1'b0; b2.cpu_addr = 32'h0000_0030;
        b2.cpu_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 1) begin busy_seen = busy2; b2.cpu_req = 1'b0; end
            if (b2.cpu_ack) begin ack_cnt++; ack_at = k; end
        end
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL pulse_busy got=%b exp=1", busy_seen); end
        checks++; if (ack_cnt != 1) begin errors++; $display("FAIL pulse_ack_count got=%0d exp=1", ack_cnt); end
        checks++; if (ack_at != 3) begin errors++; $display("FAIL pulse_ack_latency got=N+%0d exp=N+3", ack_at); end
        checks++; if (b2.cpu_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL pulse_cpu_rdata got=%h exp=0badf00d", b2.cpu_rdata); end
    endtask

    task automatic test_reset_abort();
        int ack_cnt = 0;
        @(posedge clk); #1;
        b2.mem_rdata = 32'h55AA_55AA;
        b2.cpu_we = 1'b0; b2.cpu_addr = 32'h0000_0044;
        b2.cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (b2.mem_en !== 1'b1 || busy2 !== 1'b1) begin errors++; $display("FAIL abort_in_access got=%b%b exp=11", b2.mem_en, busy2); end
        rst = 1'b1;
        b2.cpu_req = 1'b0;
        @(negedge clk);
        if (b2.cpu_ack) ack_cnt++;
        checks++; if (st2 !== 2'd0) begin errors++; $display("FAIL abort_state got=%0d exp=0", st2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy2); end
        checks++; if (b2.mem_en !== 1'b0 || b2.mem_we !== 1'b0) begin errors++; $display("FAIL abort_strobes got=%b%b exp=00", b2.mem_en, b2.mem_we); end
        checks++; if (b2.cpu_rdata !== 32'h0 || b2.ldr_rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata got=%h/%h exp=0/0", b2.cpu_rdata, b2.ldr_rdata); end
        checks++; if (b2.mem_addr !== 32'h0 || b2.mem_wdata !== 32'h0) begin errors++; $display("FAIL abort_addr_data got=%h/%h exp=0/0", b2.mem_addr, b2.mem_wdata); end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (b2.cpu_ack) ack_cnt++;
        end
        checks++; if (ack_cnt != 0) begin errors++; $display("FAIL abort_no_ack got=%0d exp=0", ack_cnt); end
    endtask

    task automatic test_wait_sweep();
        int en1 = 0, at1 = -1, en15 = 0, at15 = -1;
        @(posedge clk); #1;
        b1.mem_rdata = 32'h1111_1111;
        b1.cpu_we = 1'b0; b1.cpu_addr = 32'h0000_0050;
        b1.cpu_req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (b1.mem_en) en1++;
            if (b1.cpu_ack) begin at1 = k; b1.cpu_req = 1'b0; end
        end
        checks++; if (at1 != 2) begin errors++; $display("FAIL w1_ack_latency got=N+%0d exp=N+2", at1); end
        checks++; if (en1 != 1) begin errors++; $display("FAIL w1_mem_en_cycles got=%0d exp=1", en1); end
        checks++; if (b1.cpu_rdata !== 32'h1111_1111) begin errors++; $display("FAIL w1_cpu_rdata got=%h exp=11111111", b1.cpu_rdata); end

        @(posedge clk); #1;
        b15.mem_rdata = 32'hFFFF_0000;
        b15.ldr_we = 1'b0; b15.ldr_addr = 32'h0000_0060;
        b15.ldr_req = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (b15.mem_en) en15++;
            if (b15.ldr_ack) begin at15 = k; b15.ldr_req = 1'b0; end
        end
        checks++; if (at15 != 16) begin errors++; $display("FAIL w15_ack_latency got=N+%0d exp=N+16", at15); end
        checks++; if (en15 != 15) begin errors++; $display("FAIL w15_mem_en_cycles got=%0d exp=15", en15); end
        checks++; if (b15.ldr_rdata !== 32'hFFFF_0000) begin errors++; $display("FAIL w15_ldr_rdata got=%h exp=ffff0000", b15.ldr_rdata); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_contention();
        test_pulse_req();
        test_reset_abort();
        test_wait_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
